// File: rtl/alu_sequencer_if.sv
// Control bundle between the hardwired sequencer and the bus-based datapath.
// The datapath side presents IR and Stop; the sequencer drives every strobe.
interface alu_sequencer_if;
    logic [31:0] IR;
    logic        Stop;
    logic        PCout;
    logic        Zlowout;
    logic        MDRout;
    logic        Cout;
    logic        MARin;
    logic        PCin;
    logic        MDRin;
    logic        IRin;
    logic        Yin;
    logic        Zin;
    logic        IncPC;
    logic        Read;
    logic [4:0]  ALU_op;
    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        Rin;
    logic        Rout;
    logic        Run;
    logic        Illegal;

    // Handshake: none; every strobe is a one-cycle level sampled by the datapath
    // on the rising edge that ends the cycle in which it is high.
    modport master (
        output IR, Stop,
        input  PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, Zin,
        input  IncPC, Read, ALU_op, Gra, Grb, Grc, Rin, Rout, Run, Illegal
    );

    modport slave (
        input  IR, Stop,
        output PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, Zin,
        output IncPC, Read, ALU_op, Gra, Grb, Grc, Rin, Rout, Run, Illegal
    );
endinterface

// File: rtl/alu_sequencer.sv
// Hardwired T0-T5 control unit: fetch via MAR/MDR/IR, then reg-reg or
// reg-immediate execution through Y/Z. Moore outputs from state plus IR.
module alu_sequencer (
    input  logic                  Clock,
    input  logic                  Clear,
    alu_sequencer_if.slave        bus,
    output logic [2:0]            dbg_state
);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       illegal_q;
    logic       illegal_next;
    logic [4:0] op;
    logic       is_rr;
    logic       is_imm;
    logic [4:0] imm_alu;

    assign op        = bus.IR[31:27];
    assign dbg_state = state;

    // Reg-reg ops occupy the contiguous block add..or; ALU_op is the opcode itself.
    always_comb begin
        is_rr   = (op >= OP_ADD) && (op <= OP_OR);
        is_imm  = 1'b0;
        imm_alu = 5'b00000;
        case (op)
            OP_ADDI: begin is_imm = 1'b1; imm_alu = OP_ADD; end
            OP_ANDI: begin is_imm = 1'b1; imm_alu = OP_AND; end
            OP_ORI:  begin is_imm = 1'b1; imm_alu = OP_OR;  end
            default: begin is_imm = 1'b0; imm_alu = 5'b00000; end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state     <= S_RST;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_next;
            illegal_q <= illegal_next;
        end
    end

    // Stop only matters at the two instruction boundaries: nop's T2 and T5.
    always_comb begin
        state_next   = state;
        illegal_next = illegal_q;
        case (state)
            S_RST: state_next = S_T0;
            S_T0:  state_next = S_T1;
            S_T1:  state_next = S_T2;
            S_T2: begin
                if (is_rr || is_imm) begin
                    state_next = S_T3;
                end else if (op == OP_NOP) begin
                    state_next = bus.Stop ? S_HALT : S_T0;
                end else if (op == OP_HALT) begin
                    state_next = S_HALT;
                end else begin
                    state_next   = S_HALT;
                    illegal_next = 1'b1;
                end
            end
            S_T3:   state_next = S_T4;
            S_T4:   state_next = S_T5;
            S_T5:   state_next = bus.Stop ? S_HALT : S_T0;
            S_HALT: state_next = S_HALT;
            default: state_next = S_RST;
        endcase
    end

    // IRin depends on state alone; kept apart from the IR-decoded block so the
    // datapath can route MDR onto IR during T2 without a combinational cycle.
    assign bus.IRin    = (state == S_T2);
    assign bus.Illegal = illegal_q;

    always_comb begin
        bus.PCout   = 1'b0;
        bus.Zlowout = 1'b0;
        bus.MDRout  = 1'b0;
        bus.Cout    = 1'b0;
        bus.MARin   = 1'b0;
        bus.PCin    = 1'b0;
        bus.MDRin   = 1'b0;
        bus.Yin     = 1'b0;
        bus.Zin     = 1'b0;
        bus.IncPC   = 1'b0;
        bus.Read    = 1'b0;
        bus.ALU_op  = 5'b00000;
        bus.Gra     = 1'b0;
        bus.Grb     = 1'b0;
        bus.Grc     = 1'b0;
        bus.Rin     = 1'b0;
        bus.Rout    = 1'b0;
        bus.Run     = 1'b0;
        case (state)
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
                bus.Run   = 1'b1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                bus.Run     = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.Run    = 1'b1;
            end
            S_T3: begin
                bus.Grb  = 1'b1;
                bus.Rout = 1'b1;
                bus.Yin  = 1'b1;
                bus.Run  = 1'b1;
            end
            S_T4: begin
                bus.Zin = 1'b1;
                bus.Run = 1'b1;
                if (is_imm) begin
                    bus.Cout   = 1'b1;
                    bus.ALU_op = imm_alu;
                end else begin
                    bus.Grc    = 1'b1;
                    bus.Rout   = 1'b1;
                    bus.ALU_op = op;
                end
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                bus.Gra     = 1'b1;
                bus.Rin     = 1'b1;
                bus.Run     = 1'b1;
            end
            default: begin
                bus.Run = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a small bus datapath closes the fetch loop, and an
// instruction-level model predicts the per-cycle strobe vector.
module tb_alu_sequencer;

    localparam logic [23:0] V_PCOUT  = 24'h800000;
    localparam logic [23:0] V_ZLOW   = 24'h400000;
    localparam logic [23:0] V_MDROUT = 24'h200000;
    localparam logic [23:0] V_COUT   = 24'h100000;
    localparam logic [23:0] V_MARIN  = 24'h080000;
    localparam logic [23:0] V_PCIN   = 24'h040000;
    localparam logic [23:0] V_MDRIN  = 24'h020000;
    localparam logic [23:0] V_IRIN   = 24'h010000;
    localparam logic [23:0] V_YIN    = 24'h008000;
    localparam logic [23:0] V_ZIN    = 24'h004000;
    localparam logic [23:0] V_INCPC  = 24'h002000;
    localparam logic [23:0] V_READ   = 24'h001000;
    localparam logic [23:0] V_GRA    = 24'h000040;
    localparam logic [23:0] V_GRB    = 24'h000020;
    localparam logic [23:0] V_GRC    = 24'h000010;
    localparam logic [23:0] V_RIN    = 24'h000008;
    localparam logic [23:0] V_ROUT   = 24'h000004;
    localparam logic [23:0] V_RUN    = 24'h000002;
    localparam logic [23:0] V_ILL    = 24'h000001;

    localparam logic [23:0] T0V = V_PCOUT | V_MARIN | V_INCPC | V_ZIN | V_RUN;
    localparam logic [23:0] T1V = V_ZLOW | V_PCIN | V_READ | V_MDRIN | V_RUN;
    localparam logic [23:0] T2V = V_MDROUT | V_IRIN | V_RUN;
    localparam logic [23:0] T3V = V_GRB | V_ROUT | V_YIN | V_RUN;
    localparam logic [23:0] T5V = V_ZLOW | V_GRA | V_RIN | V_RUN;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clear = 1'b1;
    logic       stop = 1'b0;
    logic       load_rf = 1'b0;
    logic [2:0] dbg_state;

    alu_sequencer_if intf ();

    alu_sequencer dut (
        .Clock     (clk),
        .Clear     (clear),
        .bus       (intf),
        .dbg_state (dbg_state)
    );

    // ---------------- datapath ----------------
    logic [31:0] mem     [0:63];
    logic [31:0] rf      [0:15];
    logic [31:0] init_rf [0:15];
    logic [31:0] pc, mar, mdr, ir_q, y, z, bus_v, alu_v;
    logic [3:0]  ra, rb, rc, sel;

    assign intf.Stop = stop;
    assign intf.IR   = intf.IRin ? mdr : ir_q;
    assign ra = intf.IR[26:23];
    assign rb = intf.IR[22:19];
    assign rc = intf.IR[18:15];

    always_comb begin
        sel = intf.Grb ? rb : (intf.Grc ? rc : ra);
        bus_v = 32'h0;
        if (intf.PCout)        bus_v = pc;
        else if (intf.Zlowout) bus_v = z;
        else if (intf.MDRout)  bus_v = mdr;
        else if (intf.Cout)    bus_v = {{13{intf.IR[18]}}, intf.IR[18:0]};
        else if (intf.Rout)    bus_v = rf[sel];
        alu_v = bus_v;
        if (intf.IncPC) alu_v = bus_v + 32'd1;
        else begin
            case (intf.ALU_op)
                5'd3:  alu_v = y + bus_v;
                5'd4:  alu_v = y - bus_v;
                5'd5:  alu_v = y >> bus_v[4:0];
                5'd6:  alu_v = y << bus_v[4:0];
                5'd7:  alu_v = (y >> bus_v[4:0]) | (y << (6'd32 - {1'b0, bus_v[4:0]}));
                5'd8:  alu_v = (y << bus_v[4:0]) | (y >> (6'd32 - {1'b0, bus_v[4:0]}));
                5'd9:  alu_v = y & bus_v;
                5'd10: alu_v = y | bus_v;
                default: alu_v = bus_v;
            endcase
        end
    end

    always @(posedge clk) begin
        if (load_rf) for (int i = 0; i < 16; i++) rf[i] <= init_rf[i];
        if (clear) pc <= 32'h0;
        else if (intf.PCin) pc <= bus_v;
        if (intf.MARin) mar <= bus_v;
        if (intf.MDRin && intf.Read) mdr <= mem[mar[5:0]];
        if (intf.IRin) ir_q <= bus_v;
        if (intf.Yin) y <= bus_v;
        if (intf.Zin) z <= alu_v;
        if (intf.Rin && intf.Gra) rf[ra] <= bus_v;
    end

    logic [23:0] act_vec;
    assign act_vec = {intf.PCout, intf.Zlowout, intf.MDRout, intf.Cout, intf.MARin, intf.PCin,
                      intf.MDRin, intf.IRin, intf.Yin, intf.Zin, intf.IncPC, intf.Read,
                      intf.ALU_op, intf.Gra, intf.Grb, intf.Grc, intf.Rin, intf.Rout,
                      intf.Run, intf.Illegal};

    // ---------------- scoreboard / model ----------------
    logic [23:0] exp_q[$];
    logic [1:0]  stim_q[$];
    logic [23:0] last_vec = 24'h0;
    int total = 0;
    int bad = 0;
    int noise = 0;
    int cyc = 0;

    function automatic bit is_alu_op(input logic [4:0] op);
        return (op >= 5'd3 && op <= 5'd10) || (op >= 5'd12 && op <= 5'd14);
    endfunction

    function automatic bit is_defined(input logic [4:0] op);
        return is_alu_op(op) || op == 5'd26 || op == 5'd27;
    endfunction

    function automatic logic [23:0] t4_vec(input logic [4:0] op);
        logic [4:0] f;
        if (op >= 5'd12) begin
            f = (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd9 : 5'd10;
            return V_COUT | V_ZIN | V_RUN | ({19'h0, f} << 7);
        end
        return V_GRC | V_ROUT | V_ZIN | V_RUN | ({19'h0, op} << 7);
    endfunction

    function automatic logic nz();
        if (noise == 2) return 1'b1;
        if (noise == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    task automatic push(input logic [1:0] cs, input logic [23:0] v);
        stim_q.push_back(cs);
        exp_q.push_back(v);
        last_vec = v;
    endtask

    task automatic push_reset();
        push(2'b10, last_vec);
        push(2'b10, 24'h0);
        push({1'b0, nz()}, 24'h0);
    endtask

    // Expected trace of mem[0..n-1]; Stop=1 is applied only at the boundary of
    // instruction stop_idx, every other cycle carries noise that must not matter.
    task automatic model_prog(input int n, input int stop_idx);
        logic [4:0] op;
        bit done;
        bit ill;
        done = 0;
        ill = 0;
        push_reset();
        for (int i = 0; i < n && !done; i++) begin
            op = mem[i][31:27];
            push({1'b0, nz()}, T0V);
            push({1'b0, nz()}, T1V);
            if (is_alu_op(op)) begin
                push({1'b0, nz()}, T2V);
                push({1'b0, nz()}, T3V);
                push({1'b0, nz()}, t4_vec(op));
                push({1'b0, 1'(i == stop_idx)}, T5V);
                done = (i == stop_idx);
            end else if (op == 5'd26) begin
                push({1'b0, 1'(i == stop_idx)}, T2V);
                done = (i == stop_idx);
            end else begin
                push({1'b0, nz()}, T2V);
                done = 1;
                ill = (op != 5'd27);
            end
        end
        for (int k = 0; k < 4; k++) push({1'b0, nz()}, ill ? V_ILL : 24'h0);
    endtask

    // ---------------- driver ----------------
    task automatic run_trace();
        logic [1:0]  s;
        logic [23:0] e;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            clear = s[1];
            stop  = s[0];
            @(negedge clk);
            total++;
            if (act_vec !== e) begin
                bad++;
                $display("FAIL strobe_vec cyc=%0d: got %h want %h", cyc, act_vec, e);
            end
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic preload();
        load_rf = 1'b1;
        @(posedge clk);
        #1;
        load_rf = 1'b0;
    endtask

    task automatic clear_regs();
        for (int i = 0; i < 16; i++) init_rf[i] = 32'h0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] op;
        int n;
        int sidx;
        for (int i = 0; i < 64; i++) mem[i] = 32'hD800_0000;
        clear_regs();
        @(posedge clk);
        #1;
        @(negedge clk);
        check32("reset_vec", {8'h0, act_vec}, 32'h0);
        @(posedge clk);
        #1;

        // AND, addi, then nop with Stop at its T2; Stop held high elsewhere too.
        init_rf[1] = 32'h10;
        init_rf[2] = 32'h22;
        init_rf[4] = 32'h24;
        preload();
        mem[0] = 32'h4A92_0000;
        mem[1] = 32'h618F_FFFB;
        mem[2] = 32'hD000_0000;
        noise = 2;
        model_prog(3, 2);
        run_trace();
        check32("and_r5", rf[5], 32'h20);
        check32("addi_r3", rf[3], 32'h0B);
        check32("nop_stop_run", {31'h0, intf.Run}, 32'h0);

        noise = 1;
        mem[0] = 32'hD800_0000;
        model_prog(1, -1);
        run_trace();
        check32("halt_illegal", {31'h0, intf.Illegal}, 32'h0);

        mem[0] = 32'hF800_0000;
        model_prog(1, -1);
        run_trace();
        check32("illegal_flag", {31'h0, intf.Illegal}, 32'h1);
        check32("illegal_run", {31'h0, intf.Run}, 32'h0);

        // add R7,R1,R2 aborted by Clear during T4.
        clear_regs();
        init_rf[1] = 32'h5;
        init_rf[2] = 32'h6;
        init_rf[7] = 32'h77;
        preload();
        mem[0] = 32'h1B89_0000;
        noise = 0;
        push_reset();
        push(2'b00, T0V);
        push(2'b00, T1V);
        push(2'b00, T2V);
        push(2'b00, T3V);
        push(2'b10, t4_vec(5'd3));
        for (int k = 0; k < 3; k++) push(2'b10, 24'h0);
        run_trace();
        check32("abort_r7", rf[7], 32'h77);

        noise = 1;
        for (int p = 0; p < 25; p++) begin
            for (int i = 0; i < 16; i++) init_rf[i] = $urandom;
            preload();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n - 1; i++) begin
                case ($urandom_range(0, 5))
                    0, 1, 2: op = 5'($urandom_range(3, 10));
                    3, 4:    op = 5'($urandom_range(12, 14));
                    default: op = 5'd26;
                endcase
                mem[i] = {op, 27'($urandom)};
            end
            if ($urandom_range(0, 1) == 0) op = 5'd27;
            else begin
                op = 5'($urandom_range(0, 31));
                while (is_defined(op)) op = 5'($urandom_range(0, 31));
            end
            mem[n - 1] = {op, 27'($urandom)};
            sidx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            model_prog(n, sidx);
            run_trace();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
